// File: rtl/core_bus_arbiter.sv
// N-master to 1-slave memory bus arbiter: round-robin or fixed-priority grant, grant hold
// while the slave stalls, and in-order read responses routed back through a master-ID FIFO.
module core_bus_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int FIXED_PRIO      = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_MASTERS-1:0]             m_req,
   input  logic [NUM_MASTERS-1:0]             m_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0]      m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]      m_wdata,
   input  logic [NUM_MASTERS*DATA_W/8-1:0]    m_wstrb,
   output logic [NUM_MASTERS-1:0]             m_ready,
   output logic [NUM_MASTERS-1:0]             m_rvalid,
   output logic [DATA_W-1:0]                  m_rdata,
   output logic                               s_req,
   output logic                               s_we,
   output logic [ADDR_W-1:0]                  s_addr,
   output logic [DATA_W-1:0]                  s_wdata,
   output logic [DATA_W/8-1:0]                s_wstrb,
   input  logic                               s_ready,
   input  logic                               s_rvalid,
   input  logic [DATA_W-1:0]                  s_rdata,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                               err
);

   localparam int IDX_W  = $clog2(NUM_MASTERS);
   localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);
   localparam int STRB_W = DATA_W/8;

   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_lock_idx;
   logic             r_lock;
   logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   logic [IDX_W-1:0] w_grant;
   logic [IDX_W-1:0] w_grant_nxt;
   logic [IDX_W-1:0] w_head;
   logic             w_grant_we;
   logic             w_full;
   logic             w_block;
   logic             w_sreq;
   logic             w_xfer;
   logic             w_push;
   logic             w_pop;

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      return IDX_W'(sum);
   endfunction

   // Scanning from the far end down lets the nearest requester win without a found flag.
   always_comb begin : grant_select
      // NOTE: w_grant gets a default before any branch, so no path infers a latch.
      w_grant = r_rr_ptr;
      if (r_lock) begin
         w_grant = r_lock_idx;
      end else if (FIXED_PRIO != 0) begin
         for (int i = NUM_MASTERS-1; i >= 0; i--) begin
            if (m_req[i]) w_grant = IDX_W'(i);
         end
      end else begin
         for (int k = NUM_MASTERS-1; k >= 0; k--) begin
            if (m_req[rr_index(r_rr_ptr, k)]) w_grant = rr_index(r_rr_ptr, k);
         end
      end
   end

   assign w_head      = r_fifo[r_rd_ptr];
   assign w_grant_we  = m_we[w_grant];
   assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_block     = w_full && !w_grant_we;
   assign w_sreq      = (|m_req) && !w_block && !rst;
   assign w_xfer      = w_sreq && s_ready;
   assign w_push      = w_xfer && !w_grant_we;
   assign w_pop       = s_rvalid && (r_count != '0) && !rst;
   assign w_grant_nxt = (int'(w_grant) == NUM_MASTERS-1) ? '0 : w_grant + IDX_W'(1);

   // Every output is forced to zero while reset is held, independent of the clock.
   always_comb begin : out_mux
      s_req    = 1'b0;
      s_we     = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m_ready  = '0;
      m_rvalid = '0;
      m_rdata  = '0;
      if (!rst) begin
         s_req             = w_sreq;
         s_we              = w_grant_we;
         s_addr            = m_addr[int'(w_grant)*ADDR_W +: ADDR_W];
         s_wdata           = m_wdata[int'(w_grant)*DATA_W +: DATA_W];
         s_wstrb           = m_wstrb[int'(w_grant)*STRB_W +: STRB_W];
         m_ready[w_grant]  = w_xfer;
         m_rvalid[w_head]  = w_pop;
         m_rdata           = s_rdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr   <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_rr_ptr <= w_grant_nxt;
            r_lock   <= 1'b0;
         end else if (w_sreq) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (s_rvalid && (r_count == '0)) r_err <= 1'b1;
      end
   end

   // NOTE: the ID storage is not reset; the reset pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_grant;
   end

   assign outstanding = r_count;
   assign err         = r_err;

endmodule
